// File: rtl/vga_timing_cfg.sv
// Parametrised VGA/VESA timing generator: pixel/line counters with sync, blank,
// display-enable flags and line/frame strobes, all registered and mutually aligned.
module vga_timing_cfg #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblnk,
    output logic          vblnk,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_BLNK_START = H_ACTIVE;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int H_TOTAL      = H_SYNC_END + H_BP;

    localparam int V_BLNK_START = V_ACTIVE;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int V_TOTAL      = V_SYNC_END + V_BP;

    // Boundaries are held one bit wider so a window ending exactly at TOTAL = 2^CW still compares correctly.
    localparam logic [CW:0]   H_BLNK_X  = (CW+1)'(H_BLNK_START);
    localparam logic [CW:0]   H_SSTRT_X = (CW+1)'(H_SYNC_START);
    localparam logic [CW:0]   H_SEND_X  = (CW+1)'(H_SYNC_END);
    localparam logic [CW:0]   V_BLNK_X  = (CW+1)'(V_BLNK_START);
    localparam logic [CW:0]   V_SSTRT_X = (CW+1)'(V_SYNC_START);
    localparam logic [CW:0]   V_SEND_X  = (CW+1)'(V_SYNC_END);
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic          HS_ACT    = (HSYNC_POL != 0);
    localparam logic          VS_ACT    = (VSYNC_POL != 0);

    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_hblnk;
    logic          r_vblnk;
    logic          r_de;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_hcount_nxt;
    logic [CW-1:0] w_vcount_nxt;
    logic [CW:0]   w_hnxt_x;
    logic [CW:0]   w_vnxt_x;
    logic          w_hblnk_nxt;
    logic          w_vblnk_nxt;
    logic          w_hsync_act;
    logic          w_vsync_act;

    assign w_h_wrap     = (r_hcount == H_LAST);
    assign w_v_wrap     = (r_vcount == V_LAST);
    assign w_hcount_nxt = w_h_wrap ? '0 : r_hcount + ONE;
    assign w_vcount_nxt = w_h_wrap ? (w_v_wrap ? '0 : r_vcount + ONE) : r_vcount;

    // Flags are derived from the counts about to be loaded so they line up with them.
    assign w_hnxt_x    = {1'b0, w_hcount_nxt};
    assign w_vnxt_x    = {1'b0, w_vcount_nxt};
    assign w_hblnk_nxt = (w_hnxt_x >= H_BLNK_X);
    assign w_vblnk_nxt = (w_vnxt_x >= V_BLNK_X);
    assign w_hsync_act = (w_hnxt_x >= H_SSTRT_X) && (w_hnxt_x < H_SEND_X);
    assign w_vsync_act = (w_vnxt_x >= V_SSTRT_X) && (w_vnxt_x < V_SEND_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~HS_ACT;
            r_vsync       <= ~VS_ACT;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_de          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= en & w_h_wrap;
            r_frame_start <= en & w_h_wrap & w_v_wrap;
            if (en) begin
                r_hcount <= w_hcount_nxt;
                r_vcount <= w_vcount_nxt;
                r_hblnk  <= w_hblnk_nxt;
                r_vblnk  <= w_vblnk_nxt;
                r_de     <= ~w_hblnk_nxt & ~w_vblnk_nxt;
                r_hsync  <= w_hsync_act ? HS_ACT : ~HS_ACT;
                r_vsync  <= w_vsync_act ? VS_ACT : ~VS_ACT;
            end
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_cfg.sv
// Scoreboard bench for vga_timing_cfg in a small mode (mixed sync polarity),
// driven by random enable/reset patterns against an arithmetic reference model.
module tb_vga_timing_cfg;

    localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
    localparam int VA = 6,  VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int HPOL = 0, VPOL = 1;
    localparam int CW = 5;

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit hb;
        bit vb;
        bit de;
        bit ls;
        bit fs;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync, vsync, hblnk, vblnk, de, line_start, frame_start;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   mH = 0, mV = 0;
    bit   mLs = 0, mFs = 0;

    vga_timing_cfg #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync),
        .hblnk(hblnk), .vblnk(vblnk), .de(de),
        .line_start(line_start), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for the model's current position, straight from the window rules.
    function automatic exp_t modelOut();
        exp_t e;
        bit hAct, vAct;
        hAct = (mH >= HA + HFP) && (mH < HA + HFP + HS);
        vAct = (mV >= VA + VFP) && (mV < VA + VFP + VS);
        e.h  = mH;
        e.v  = mV;
        e.hb = (mH >= HA);
        e.vb = (mV >= VA);
        e.de = (mH < HA) && (mV < VA);
        e.hs = hAct ? (HPOL != 0) : (HPOL == 0);
        e.vs = vAct ? (VPOL != 0) : (VPOL == 0);
        e.ls = mLs;
        e.fs = mFs;
        return e;
    endfunction

    task automatic compareField(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("hcount",      int'(hcount),      e.h);
        compareField("vcount",      int'(vcount),      e.v);
        compareField("hsync",       int'(hsync),       int'(e.hs));
        compareField("vsync",       int'(vsync),       int'(e.vs));
        compareField("hblnk",       int'(hblnk),       int'(e.hb));
        compareField("vblnk",       int'(vblnk),       int'(e.vb));
        compareField("de",          int'(de),          int'(e.de));
        compareField("line_start",  int'(line_start),  int'(e.ls));
        compareField("frame_start", int'(frame_start), int'(e.fs));
    endtask

    // One clock of stimulus: drive at the falling edge, advance the model, queue the expectation.
    task automatic applyStimulus(input bit doReset, input bit enVal);
        @(negedge clk);
        en = enVal;
        if (doReset) begin
            rst_n = 1'b0;
            mH = 0; mV = 0; mLs = 0; mFs = 0;
            #1 checkOutput(modelOut());
        end else begin
            rst_n = 1'b1;
            if (enVal) begin
                mH = (mH + 1) % HT;
                if (mH == 0) mV = (mV + 1) % VT;
                mLs = (mH == 0);
                mFs = mLs && (mV == 0);
            end else begin
                mLs = 0;
                mFs = 0;
            end
        end
        expQ.push_back(modelOut());
    endtask

    // Monitor: every output cycle is compared against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #500us;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b0);
        repeat (3 * HT * VT / 2) applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 1500; k++) applyStimulus(1'b0, (k % 2) == 0);
        for (int k = 0; k < 2000 && (mV != VT / 2 || mH != 7); k++) applyStimulus(1'b0, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
        repeat (10) applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 3000; k++)
            applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
        repeat (3) @(posedge clk);
        #2;
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
